// File: rtl/seg_display.sv
// Multi-digit seven-segment driver with parallel per-digit outputs and a scanned bus.
// Adds leading-zero suppression, per-digit blink and live enable gating; every output is registered.
module seg_display #(
    parameter int DIGITS       = 8,
    parameter int BLINK_PERIOD = 25_000_000,
    parameter int SCAN_DIV     = 50_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    output logic [8*DIGITS-1:0]   seg_out,
    output logic [7:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_sel,
    output logic                  blink_phase
);
    localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hFC;
            4'h1:    pat = 8'h60;
            4'h2:    pat = 8'hDA;
            4'h3:    pat = 8'hF2;
            4'h4:    pat = 8'h66;
            4'h5:    pat = 8'hB6;
            4'h6:    pat = 8'hBE;
            4'h7:    pat = 8'hE0;
            4'h8:    pat = 8'hFE;
            4'h9:    pat = 8'hF6;
            4'hA:    pat = 8'hEE;
            4'hB:    pat = 8'h3E;
            4'hC:    pat = 8'h9C;
            4'hD:    pat = 8'h7A;
            4'hE:    pat = 8'h9E;
            4'hF:    pat = 8'h8E;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    // Active-low digit byte: decoded segments with the dp bit substituted.
    function automatic logic [7:0] lit_byte(input logic [3:0] nib, input logic dp_bit);
        logic [7:0] pat;
        pat    = hex_to_seg(nib);
        pat[0] = dp_bit;
        return ~pat;
    endfunction

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   blink_mask_q, blink_mask_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [SW-1:0]       scan_div_q, scan_div_d;
    logic [IW-1:0]       scan_idx_q, scan_idx_d;
    logic [8*DIGITS-1:0] seg_out_q, seg_out_d;
    logic [7:0]          scan_seg_q, scan_seg_d;
    logic [DIGITS-1:0]   scan_sel_q, scan_sel_d;

    logic [DIGITS-1:0]   lead_zero_s;
    logic [8*DIGITS-1:0] digit_s;

    // Capture registers follow the load strobe.
    always_comb begin
        if (load) begin
            value_d      = value;
            dp_d         = dp;
            blink_mask_d = blink_mask;
        end else begin
            value_d      = value_q;
            dp_d         = dp_q;
            blink_mask_d = blink_mask_q;
        end
    end

    // Free-running blink and scan timebases, independent of en and load.
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BW'(1);
            blink_phase_d = blink_phase_q;
        end
        if (scan_div_q == SCAN_LAST) begin
            scan_div_d = '0;
            if (scan_idx_q == IDX_LAST) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IW'(1);
            end
        end else begin
            scan_div_d = scan_div_q + SW'(1);
            scan_idx_d = scan_idx_q;
        end
    end

    // lead_zero_s[i]: nibbles i..top are all zero.
    always_comb begin
        lead_zero_s           = '0;
        lead_zero_s[DIGITS-1] = (value_q[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero_s[i] = lead_zero_s[i+1] && (value_q[4*i +: 4] == 4'h0);
        end
    end

    // Per-digit byte: blink blanks everything, suppression keeps only the dp.
    always_comb begin
        digit_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_phase_q && blink_mask_q[i]) begin
                digit_s[8*i +: 8] = 8'hFF;
            end else if (lz_en && (i != 0) && lead_zero_s[i]) begin
                digit_s[8*i +: 8] = {7'h7F, ~dp_q[i]};
            end else begin
                digit_s[8*i +: 8] = lit_byte(value_q[4*i +: 4], dp_q[i]);
            end
        end
    end

    // Scan bus samples the same next-cycle digit bytes so both views stay coherent.
    always_comb begin
        if (en) begin
            seg_out_d  = digit_s;
            scan_seg_d = digit_s[8*scan_idx_q +: 8];
            scan_sel_d = ~(DIGITS'(1) << scan_idx_q);
        end else begin
            seg_out_d  = '1;
            scan_seg_d = 8'hFF;
            scan_sel_d = '1;
        end
    end

    // State and output registers; reset wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q       <= '0;
            dp_q          <= '0;
            blink_mask_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            scan_div_q    <= '0;
            scan_idx_q    <= '0;
            seg_out_q     <= '1;
            scan_seg_q    <= 8'hFF;
            scan_sel_q    <= '1;
        end else begin
            value_q       <= value_d;
            dp_q          <= dp_d;
            blink_mask_q  <= blink_mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_div_q    <= scan_div_d;
            scan_idx_q    <= scan_idx_d;
            seg_out_q     <= seg_out_d;
            scan_seg_q    <= scan_seg_d;
            scan_sel_q    <= scan_sel_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign scan_seg    = scan_seg_q;
    assign scan_sel    = scan_sel_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display: an 8-digit and a 4-digit instance checked every cycle against
// an arithmetic model, plus hand-computed expectations for the key scenarios.
module tb_seg_display;
    localparam int D8 = 8, BP8 = 4, SD8 = 3;
    localparam int D4 = 4, BP4 = 6, SD4 = 2;
    localparam logic [7:0] SEG_TAB [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, load, lz_en;
    logic [31:0] value8;
    logic [7:0]  dp8, mask8;
    logic [15:0] value4;
    logic [3:0]  dp4, mask4;
    logic [63:0] seg8;
    logic [7:0]  scan_seg8, scan_sel8;
    logic        ph8;
    logic [31:0] seg4;
    logic [7:0]  scan_seg4;
    logic [3:0]  scan_sel4;
    logic        ph4;

    int errors = 0;
    int checks = 0;

    seg_display #(.DIGITS(D8), .BLINK_PERIOD(BP8), .SCAN_DIV(SD8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value8), .dp(dp8),
        .blink_mask(mask8), .lz_en(lz_en), .seg_out(seg8), .scan_seg(scan_seg8),
        .scan_sel(scan_sel8), .blink_phase(ph8));

    seg_display #(.DIGITS(D4), .BLINK_PERIOD(BP4), .SCAN_DIV(SD4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value4), .dp(dp4),
        .blink_mask(mask4), .lz_en(lz_en), .seg_out(seg4), .scan_seg(scan_seg4),
        .scan_sel(scan_sel4), .blink_phase(ph4));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Display contents straight from the rules: blink, then suppression, then decode.
    function automatic logic [127:0] model_digits(input logic [63:0] val, input logic [15:0] dpv,
                                                  input logic [15:0] msk, input int nd,
                                                  input logic lz, input logic ph);
        logic [127:0] r;
        logic [7:0]   pat;
        bit           upper_zero;
        r = '1;
        for (int i = 0; i < nd; i++) begin
            upper_zero = 1'b1;
            for (int j = i; j < nd; j++) begin
                if (val[4*j +: 4] != 4'h0) upper_zero = 1'b0;
            end
            if (ph && msk[i]) begin
                r[8*i +: 8] = 8'hFF;
            end else if (lz && i > 0 && upper_zero) begin
                r[8*i +: 8] = dpv[i] ? 8'hFE : 8'hFF;
            end else begin
                pat = SEG_TAB[val[4*i +: 4]];
                pat[0] = dpv[i];
                r[8*i +: 8] = ~pat;
            end
        end
        return r;
    endfunction

    logic [31:0] m8_val;  logic [7:0] m8_dp, m8_mask;  int n8;
    logic [15:0] m4_val;  logic [3:0] m4_dp, m4_mask;  int n4;
    logic [63:0] e8_seg;  logic [7:0] e8_sseg, e8_ssel; logic e8_ph;
    logic [31:0] e4_seg;  logic [7:0] e4_sseg; logic [3:0] e4_ssel; logic e4_ph;
    logic [127:0] d8, d4;
    int idx8, idx4;
    bit mvalid = 1'b0;

    // Model: n counts edges since reset; phase = (n/BP)%2, scan index = (n/SD)%D.
    always @(posedge clk) begin
        if (rst) begin
            m8_val = '0; m8_dp = '0; m8_mask = '0; n8 = 0;
            m4_val = '0; m4_dp = '0; m4_mask = '0; n4 = 0;
            e8_seg = '1; e8_sseg = 8'hFF; e8_ssel = 8'hFF; e8_ph = 1'b0;
            e4_seg = '1; e4_sseg = 8'hFF; e4_ssel = 4'hF;  e4_ph = 1'b0;
            mvalid = 1'b1;
        end else begin
            d8 = model_digits(64'(m8_val), 16'(m8_dp), 16'(m8_mask), D8, lz_en, ((n8 / BP8) % 2) == 1);
            d4 = model_digits(64'(m4_val), 16'(m4_dp), 16'(m4_mask), D4, lz_en, ((n4 / BP4) % 2) == 1);
            idx8 = (n8 / SD8) % D8;
            idx4 = (n4 / SD4) % D4;
            e8_seg  = en ? d8[63:0] : '1;
            e8_sseg = en ? d8[8*idx8 +: 8] : 8'hFF;
            e8_ssel = en ? ~(8'(1) << idx8) : 8'hFF;
            e4_seg  = en ? d4[31:0] : '1;
            e4_sseg = en ? d4[8*idx4 +: 8] : 8'hFF;
            e4_ssel = en ? ~(4'(1) << idx4) : 4'hF;
            n8++;
            n4++;
            e8_ph = ((n8 / BP8) % 2) == 1;
            e4_ph = ((n4 / BP4) % 2) == 1;
            if (load) begin
                m8_val = value8; m8_dp = dp8; m8_mask = mask8;
                m4_val = value4; m4_dp = dp4; m4_mask = mask4;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            check("seg8", seg8, e8_seg);
            check("scan_seg8", 64'(scan_seg8), 64'(e8_sseg));
            check("scan_sel8", 64'(scan_sel8), 64'(e8_ssel));
            check("phase8", 64'(ph8), 64'(e8_ph));
            check("seg4", 64'(seg4), 64'(e4_seg));
            check("scan_seg4", 64'(scan_seg4), 64'(e4_sseg));
            check("scan_sel4", 64'(scan_sel4), 64'(e4_ssel));
            check("phase4", 64'(ph4), 64'(e4_ph));
        end
    end

    task automatic do_load(input logic [31:0] v8, input logic [7:0] dv8, input logic [7:0] mv8,
                           input logic [15:0] v4, input logic [3:0] dv4, input logic [3:0] mv4);
        value8 = v8; dp8 = dv8; mask8 = mv8;
        value4 = v4; dp4 = dv4; mask4 = mv4;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    logic [3:0] sel_tab [8] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
    logic [7:0] sseg_tab [8] = '{8'h9F, 8'h25, 8'h25, 8'h0D, 8'h0D, 8'h99, 8'h99, 8'h9F};
    int dark, ph_hi;
    logic d0_ok;

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; lz_en = 1'b0;
        value8 = '1; dp8 = '1; mask8 = '0;
        value4 = '1; dp4 = '1; mask4 = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", seg8, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_sel", 64'(scan_sel8), 64'hFF);
        check("rst_phase", 64'(ph8), 64'h0);
        rst = 1'b0; load = 1'b0; value8 = '0; dp8 = '0; value4 = '0; dp4 = '0;
        @(negedge clk);
        check("rel_seg", seg8, 64'h0303_0303_0303_0303);
        check("rel_sel", 64'(scan_sel8), 64'hFE);

        lz_en = 1'b1;
        do_load(32'h0000_00A5, 8'h01, 8'h00, 16'h00A5, 4'h1, 4'h0);
        check("lz_a5", seg8, 64'hFFFF_FFFF_FFFF_1148);
        lz_en = 1'b0;
        @(negedge clk);
        check("nolz_a5", seg8, 64'h0303_0303_0303_1148);

        lz_en = 1'b1;
        do_load(32'h0, 8'h00, 8'h00, 16'h0, 4'h0, 4'h0);
        check("lz_zero", seg8, 64'hFFFF_FFFF_FFFF_FF03);
        do_load(32'h1000_0000, 8'h00, 8'h00, 16'h1000, 4'h0, 4'h0);
        check("lz_top", seg8, 64'h9F03_0303_0303_0303);

        lz_en = 1'b0;
        do_load(32'h0000_0021, 8'h00, 8'h01, 16'h0021, 4'h0, 4'h1);
        dark = 0; ph_hi = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (seg8[7:0] == 8'hFF) dark++;
            if (ph8) ph_hi++;
            d0_ok = (seg8[7:0] == 8'hFF) || (seg8[7:0] == 8'h9F);
            check("blink_d0", 64'(d0_ok), 64'h1);
            check("blink_d1", 64'(seg8[15:8]), 64'h25);
        end
        check("blink_dark", 64'(dark), 64'd4);
        check("blink_phase_hi", 64'(ph_hi), 64'd4);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        value4 = 16'h4321; dp4 = '0; mask4 = '0; value8 = 32'h4321; dp8 = '0; mask8 = '0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("scan_sel_seq", 64'(scan_sel4), 64'(sel_tab[k]));
            check("scan_seg_seq", 64'(scan_seg4), 64'(sseg_tab[k]));
        end
        rst = 1'b1;
        @(negedge clk);
        check("midscan_rst_sel", 64'(scan_sel4), 64'hF);
        rst = 1'b0;
        @(negedge clk);
        check("restart_sel", 64'(scan_sel4), 64'hE);

        lz_en = 1'b1;
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                value8 = 32'h0000_000F; dp8 = '0; mask8 = '0;
                value4 = 16'h000F; dp4 = '0; mask4 = '0;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            check("en_off_seg", seg8, 64'hFFFF_FFFF_FFFF_FFFF);
            check("en_off_sseg", 64'(scan_seg8), 64'hFF);
            check("en_off_sel", 64'(scan_sel8), 64'hFF);
        end
        en = 1'b1;
        @(negedge clk);
        check("en_on_seg", seg8, 64'hFFFF_FFFF_FFFF_FF71);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
